hc165_button_scanner: RTL and testbench
=======================================

Name: hc165_button_scanner

Overview:
- Upstream input stage for the 7-seg clock. Reads the HR++/MIN++/display-select buttons through a chain of 74HC165 parallel-in shift registers, so all buttons share three pins.
- Debounces each button per scan.
- Emits one-cycle press pulses, with optional hold-to-repeat, that drive the BCD counters' increment inputs and the display-state logic.
- Mirrors the 74HC595 output chain: generated sclk, load strobe and serial data.

Parameters:
- NUM_BTNS, 8: buttons in chain; 8 per 74HC165.
- CLK_DIV, 8: clk cycles per sclk half-period and per load pulse; ≥1.
- SCAN_PERIOD, 10000: clk cycles between scan starts, start-to-start (1 ms at 10 MHz).
- DEBOUNCE_SCANS, 4: consecutive differing scans needed to flip a stable state; ≥1.
- REPEAT_DELAY, 500: scans held before the first repeat pulse.
- REPEAT_RATE, 100: scans between subsequent repeat pulses.
- REPEAT_EN, 8'h03: per-button repeat enable mask; bit i enables button i.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: asynchronous active-low reset.
- enable_i  in  1: scanning enabled.
- qh_i  in  1: serial data from the last 74HC165 QH pin.
- sh_ld_n_o  out  1: 74HC165 SH/LD_n; low = parallel load.
- sclk_o  out  1: 74HC165 CLK; rising edge shifts.
- btn_state_o  out  NUM_BTNS: debounced level; 1 = pressed (buttons active-high).
- btn_press_o  out  NUM_BTNS: one-clk pulse per press event and per repeat.
- scan_done_o  out  1: one-clk pulse at the end of every scan.

Behaviour:
- Clock and reset:
  - Single clock domain. The clock port is clk; the reset port is rst_n, asynchronous, active-low.
  - Reset values: sh_ld_n_o=1, sclk_o=0, btn_state_o=0, btn_press_o=0, scan_done_o=0. All counters are 0 and the FSM is in IDLE.
  - Reset mid-scan aborts immediately; outputs go to reset values asynchronously.
- Scan timer:
  - Free-running 0..SCAN_PERIOD-1.
  - Wrap sets a start request, held until it is consumed in IDLE.
  - If a scan outlasts SCAN_PERIOD, the next scan starts in the cycle after UPDATE; requests never queue beyond one.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, UPDATE.
  - IDLE: if start request and enable_i are both set, go to LOAD.
  - LOAD: sh_ld_n_o=0 for CLK_DIV cycles, then go to SHIFT_LO with bit index k=0.
  - SHIFT_LO: sh_ld_n_o=1, sclk_o=0 for CLK_DIV cycles. On the last cycle, capture qh_i into shift bit NUM_BTNS-1-k (MSB first; first bit = button NUM_BTNS-1). If k==NUM_BTNS-1, go to UPDATE; else go to SHIFT_HI.
  - SHIFT_HI: sclk_o=1 for CLK_DIV cycles, k++, then go to SHIFT_LO.
  - UPDATE: 1 cycle. Apply debounce and repeat to all buttons in parallel, then go to IDLE.
  - Scan length = CLK_DIV·(2·NUM_BTNS) + 1 clk.
- Registered outputs:
  - btn_state_o, btn_press_o and scan_done_o update on the clk edge that ends UPDATE.
  - Pulses are high for exactly one clk, in the cycle after UPDATE.
  - Latency from the final qh_i capture to pulse high is 2 clk.
- Debounce, per button:
  - If raw == stable, clear the counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_SCANS, flip stable and clear the counter.
  - A stable 0→1 flip sets btn_press_o[i]. A release produces no pulse.
- Repeat, per button with REPEAT_EN[i]=1 while stable=1:
  - The hold counter counts scans from the press.
  - Pulse when the count equals REPEAT_DELAY, then every REPEAT_RATE scans after that.
  - The counter saturates and does not wrap; it clears on release.
  - Buttons with REPEAT_EN[i]=0 never repeat.
- Simultaneous events: any combination of buttons may pulse in the same cycle. Press and repeat cannot coincide, since the hold count is 0 at press.
- enable_i low:
  - A scan in progress completes.
  - No new scans start, the pending request is dropped, and btn_state_o holds.
  - Re-enabling waits for the next timer wrap.
- Width rules: counters sized with $clog2 of (max+1). The hold counter is sized for REPEAT_DELAY+REPEAT_RATE.

Decomposition:
- Package hc165_scan_pkg holds:
  - the FSM state enum (IDLE, LOAD, SHIFT_LO, SHIFT_HI, UPDATE);
  - width helper constants for scan, debounce and hold counters.
- Sub-module btn_debounce_repeat: one per button via generate. Inputs: raw bit, update strobe, repeat enable. Outputs: stable, press pulse.
- The top keeps the timer, FSM and shift register.

Test Plan:
Bench parameters: NUM_BTNS=8, CLK_DIV=2, SCAN_PERIOD=64, DEBOUNCE_SCANS=3, REPEAT_DELAY=5, REPEAT_RATE=2, REPEAT_EN=8'h03. A 74HC165 model sits on the pins.
- Waveform: after reset, first scan at clk 64 → sh_ld_n_o low 2 clk, then 8 samples and 7 sclk rising edges, 2 clk per half-period; scan_done_o pulses once at start+33.
- Bit order: parallel input 8'b1000_0001 held for 3 scans → btn_state_o=8'h81 after the 3rd scan's UPDATE; btn_press_o=8'h81 for exactly 1 clk.
- Bounce: button 2 toggles every scan for 10 scans, then holds 1 → no pulse during toggling; a single pulse on bit 2 exactly 3 scans after it settles.
- Repeat: hold button 0 for 12 scans after press → pulses at press and at hold scans 5, 7, 9, 11; button 7 held the same way → only the press pulse.
- enable_i low mid-scan → current scan completes (scan_done_o pulses); no further sh_ld_n_o low while disabled; btn_state_o unchanged.
- rst_n low during SHIFT_HI → sclk_o=0, sh_ld_n_o=1, btn_state_o=0 asynchronously; first scan restarts 64 clk after release.

Source files
------------

// File: rtl/hc165_scan_pkg.sv
// Shared types and width helpers for the 74HC165 button scanner.
package hc165_scan_pkg;

  // Scan sequencer states: parallel load, then alternating sclk low/high
  // half-periods per bit, then one cycle to apply debounce and repeat.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    UPDATE
  } scan_state_e;

  // Bits needed to hold 0..max_val. Always at least 1 so degenerate
  // parameter choices still produce legal vectors.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Scan timer runs 0..period-1.
  function automatic int scan_cnt_w(input int period);
    return cnt_width(period - 1);
  endfunction

  // Debounce counter must be able to reach the threshold value.
  function automatic int db_cnt_w(input int scans);
    return cnt_width(scans);
  endfunction

  // Hold counter must be able to reach the first repeat plus one period.
  function automatic int hold_cnt_w(input int delay, input int rate);
    return cnt_width(delay + rate);
  endfunction

endpackage

// File: rtl/hc165_button_scanner_if.sv
// Pin-level bus to the 74HC165 chain: load strobe, shift clock, serial data.
interface hc165_button_scanner_if;
  logic sh_ld_n_o;
  logic sclk_o;
  logic qh_i;

  // Scanner side drives the strobes and reads the chain output.
  modport master (output sh_ld_n_o, output sclk_o, input qh_i);
  // Shift-register chain side.
  modport slave  (input sh_ld_n_o, input sclk_o, output qh_i);
endinterface

// File: rtl/hc165_button_scanner_btn_debounce_repeat.sv
// Per-button debounce filter with press pulse and optional hold-to-repeat.
// All state advances only on update_i, i.e. once per completed scan.
module btn_debounce_repeat
  import hc165_scan_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic update_i,
  input  logic repeat_en_i,
  output logic stable_o,
  output logic press_o
);

  localparam int DB_W     = db_cnt_w(DEBOUNCE_SCANS);
  localparam int HOLD_W   = hold_cnt_w(REPEAT_DELAY, REPEAT_RATE);
  localparam int HOLD_MAX = REPEAT_DELAY + REPEAT_RATE;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_SCANS - 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRST  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_SECOND = HOLD_W'(HOLD_MAX);

  logic              stable_q, stable_d;
  logic              press_q,  press_d;
  logic [DB_W-1:0]   db_q,     db_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic [HOLD_W-1:0] hold_inc;

  assign hold_inc = hold_q + 1'b1;

  // Next-state for debounce counter, stable level, hold counter and pulse.
  // NOTE: every variable gets a default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    stable_d = stable_q;
    db_d     = db_q;
    hold_d   = hold_q;
    press_d  = 1'b0;

    if (update_i) begin
      if (raw_i == stable_q) begin
        db_d = '0;
      end else if (db_q == DB_LAST) begin
        db_d     = '0;
        stable_d = ~stable_q;
        press_d  = ~stable_q;   // only the 0->1 flip is a press event
        hold_d   = '0;
      end else begin
        db_d = db_q + 1'b1;
      end

      // Repeat only while the button stays held through this scan. On the
      // second repeat point the count folds back to the first one, so it
      // never exceeds REPEAT_DELAY+REPEAT_RATE and then pulses every
      // REPEAT_RATE scans indefinitely.
      if (stable_q && stable_d && repeat_en_i) begin
        hold_d = hold_inc;
        if (hold_inc == HOLD_FIRST) begin
          press_d = 1'b1;
        end
        if (hold_inc == HOLD_SECOND) begin
          press_d = 1'b1;
          hold_d  = HOLD_FIRST;
        end
      end else if (!stable_d) begin
        hold_d = '0;
      end
    end
  end

  // Per-button state registers; the pulse register self-clears each cycle.
  // NOTE: sequential state uses non-blocking assignment only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      db_q     <= '0;
      hold_q   <= '0;
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      db_q     <= db_d;
      hold_q   <= hold_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/hc165_button_scanner.sv
// Button scanner for a 74HC165 chain: periodic scan timer, load/shift
// sequencer, serial capture, and one debounce/repeat filter per button.
module hc165_button_scanner
  import hc165_scan_pkg::*;
#(
  parameter int                  NUM_BTNS       = 8,
  parameter int                  CLK_DIV        = 8,
  parameter int                  SCAN_PERIOD    = 10000,
  parameter int                  DEBOUNCE_SCANS = 4,
  parameter int                  REPEAT_DELAY   = 500,
  parameter int                  REPEAT_RATE    = 100,
  parameter logic [NUM_BTNS-1:0] REPEAT_EN      = NUM_BTNS'(8'h03)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  hc165_button_scanner_if.master  hc_bus,
  output logic [NUM_BTNS-1:0]     btn_state_o,
  output logic [NUM_BTNS-1:0]     btn_press_o,
  output logic                    scan_done_o
);

  localparam int SCAN_W = scan_cnt_w(SCAN_PERIOD);
  localparam int DIV_W  = cnt_width(CLK_DIV - 1);
  localparam int BIT_W  = cnt_width(NUM_BTNS - 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NUM_BTNS - 1);

  scan_state_e         state_q, state_d;
  logic [SCAN_W-1:0]   timer_q;
  logic                req_q, req_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [NUM_BTNS-1:0] shreg_q, shreg_d;
  logic                sh_ld_n_q, sclk_q, scan_done_q;

  logic timer_wrap;
  logic start_pending;
  logic phase_end;
  logic update;

  assign timer_wrap    = (timer_q == SCAN_LAST);
  // The wrap itself counts as a request so a scan starts on the
  // SCAN_PERIOD boundary rather than one cycle later.
  assign start_pending = req_q | timer_wrap;
  assign phase_end     = (div_q == DIV_LAST);
  assign update        = (state_q == UPDATE);

  // Free-running scan period timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (timer_wrap) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Sequencer next-state: phase timing, bit index, serial capture, request.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    // Outside IDLE a wrap latches one request; a second wrap merges into it.
    req_d   = start_pending;

    unique case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        // Consumed when starting, dropped when disabled.
        req_d = 1'b0;
        if (start_pending && enable_i) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (phase_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT_LO;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT_LO: begin
        if (phase_end) begin
          div_d = '0;
          // First bit out of the chain belongs to the highest button.
          shreg_d[BIT_LAST - bit_q] = hc_bus.qh_i;
          state_d = (bit_q == BIT_LAST) ? UPDATE : SHIFT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT_HI: begin
        if (phase_end) begin
          div_d   = '0;
          bit_d   = bit_q + 1'b1;
          state_d = SHIFT_LO;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      UPDATE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers and pin strobes. Strobes are registered from the
  // next state so the pins are glitch-free and track state_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      sh_ld_n_q   <= 1'b1;
      sclk_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      sh_ld_n_q   <= (state_d != LOAD);
      sclk_q      <= (state_d == SHIFT_HI);
      scan_done_q <= update;
    end
  end

  assign hc_bus.sh_ld_n_o = sh_ld_n_q;
  assign hc_bus.sclk_o    = sclk_q;
  assign scan_done_o      = scan_done_q;

  // One debounce/repeat filter per button, all stepped by the UPDATE cycle.
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce_repeat #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_btn (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_i       (shreg_q[i]),
      .update_i    (update),
      .repeat_en_i (REPEAT_EN[i]),
      .stable_o    (btn_state_o[i]),
      .press_o     (btn_press_o[i])
    );
  end

endmodule

// File: tb/tb_hc165_button_scanner.sv
// Directed bench for hc165_button_scanner with a 74HC165 model on the pins.
module tb_hc165_button_scanner;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [NB-1:0] par = '0;
  logic [NB-1:0] sr = '0;
  logic [NB-1:0] btn_state, btn_press;
  logic          scan_done;

  int checks = 0;
  int errors = 0;

  hc165_button_scanner_if bus ();

  hc165_button_scanner #(
    .NUM_BTNS       (NB),
    .CLK_DIV        (2),
    .SCAN_PERIOD    (64),
    .DEBOUNCE_SCANS (3),
    .REPEAT_DELAY   (5),
    .REPEAT_RATE    (2),
    .REPEAT_EN      (8'h03)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .hc_bus      (bus),
    .btn_state_o (btn_state),
    .btn_press_o (btn_press),
    .scan_done_o (scan_done)
  );

  always #5 clk = ~clk;

  // 74HC165 chain model: load on SH/LD_n low, shift A->H on CLK rise, QH = H.
  always @(negedge bus.sh_ld_n_o or posedge bus.sclk_o) begin
    if (!bus.sh_ld_n_o) sr <= par;
    else                sr <= {sr[NB-2:0], 1'b0};
  end
  assign bus.qh_i = sr[NB-1];

  // Wait (bounded) for the scan_done pulse; sampled on the falling edge.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (scan_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL scan_done_timeout: no scan_done within 200 clk");
    end
  endtask

  // Present a parallel pattern, run one scan, return the outputs at the pulse.
  task automatic run_scan(input logic [NB-1:0] p, output logic [NB-1:0] st,
                          output logic [NB-1:0] pr);
    bit ok;
    par = p;
    wait_done(ok);
    st = ok ? btn_state : 'x;
    pr = ok ? btn_press : 'x;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.sh_ld_n_o !== 1'b1) begin errors++; $display("FAIL rst_sh_ld_n: got %b want 1", bus.sh_ld_n_o); end
    if (bus.sclk_o !== 1'b0)    begin errors++; $display("FAIL rst_sclk: got %b want 0", bus.sclk_o); end
    if (btn_state !== 8'h00)    begin errors++; $display("FAIL rst_state: got %h want 00", btn_state); end
    if (btn_press !== 8'h00)    begin errors++; $display("FAIL rst_press: got %h want 00", btn_press); end
    if (scan_done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b want 0", scan_done); end
  endtask

  // Release reset and profile the first scan edge by edge.
  task automatic test_waveform();
    int   first_low = -1, low_cnt = 0, first_sclk = -1, rises = 0;
    int   first_done = -1, done_cnt = 0;
    logic sclk_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 110; e++) begin
      @(negedge clk);
      if (bus.sh_ld_n_o === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = e;
      end
      if (bus.sclk_o === 1'b1 && sclk_prev === 1'b0) begin
        rises++;
        if (first_sclk < 0) first_sclk = e;
      end
      sclk_prev = bus.sclk_o;
      if (scan_done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = e;
      end
    end
    checks += 6;
    if (first_low !== 64)  begin errors++; $display("FAIL wf_load_start: got %0d want 64", first_low); end
    if (low_cnt !== 2)     begin errors++; $display("FAIL wf_load_len: got %0d want 2", low_cnt); end
    if (first_sclk !== 68) begin errors++; $display("FAIL wf_first_sclk: got %0d want 68", first_sclk); end
    if (rises !== 7)       begin errors++; $display("FAIL wf_sclk_rises: got %0d want 7", rises); end
    if (first_done !== 97) begin errors++; $display("FAIL wf_done_at: got %0d want 97", first_done); end
    if (done_cnt !== 1)    begin errors++; $display("FAIL wf_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_bit_order();
    logic [NB-1:0] p[6]  = '{8'h81, 8'h81, 8'h81, 8'h00, 8'h00, 8'h00};
    logic [NB-1:0] es[6] = '{8'h00, 8'h00, 8'h81, 8'h81, 8'h81, 8'h00};
    logic [NB-1:0] ep[6] = '{8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00};
    logic [NB-1:0] st, pr;
    for (int i = 0; i < 6; i++) begin
      run_scan(p[i], st, pr);
      checks += 2;
      if (st !== es[i]) begin errors++; $display("FAIL order_state[%0d]: got %h want %h", i, st, es[i]); end
      if (pr !== ep[i]) begin errors++; $display("FAIL order_press[%0d]: got %h want %h", i, pr, ep[i]); end
      if (i == 2) begin
        @(negedge clk);
        checks++;
        if (btn_press !== 8'h00) begin errors++; $display("FAIL order_pulse_width: got %h want 00", btn_press); end
      end
    end
  endtask

  task automatic test_bounce();
    logic [NB-1:0] st, pr;
    logic [NB-1:0] p[6]  = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00};
    logic [NB-1:0] es[6] = '{8'h00, 8'h00, 8'h04, 8'h04, 8'h04, 8'h00};
    logic [NB-1:0] ep[6] = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) begin
      run_scan((i % 2 == 0) ? 8'h04 : 8'h00, st, pr);
      checks += 2;
      if (st !== 8'h00) begin errors++; $display("FAIL bounce_state[%0d]: got %h want 00", i, st); end
      if (pr !== 8'h00) begin errors++; $display("FAIL bounce_press[%0d]: got %h want 00", i, pr); end
    end
    for (int i = 0; i < 6; i++) begin
      run_scan(p[i], st, pr);
      checks += 2;
      if (st !== es[i]) begin errors++; $display("FAIL settle_state[%0d]: got %h want %h", i, st, es[i]); end
      if (pr !== ep[i]) begin errors++; $display("FAIL settle_press[%0d]: got %h want %h", i, pr, ep[i]); end
    end
  endtask

  // Button 0 repeats, button 7 does not. Release scan 1 still sees stable=1
  // with hold count reaching 7, so button 0 gets one more repeat there.
  task automatic test_repeat();
    logic [NB-1:0] st, pr, exp_pr;
    logic [NB-1:0] p[6]  = '{8'h81, 8'h81, 8'h81, 8'h00, 8'h00, 8'h00};
    logic [NB-1:0] es[6] = '{8'h00, 8'h00, 8'h81, 8'h81, 8'h81, 8'h00};
    logic [NB-1:0] ep[6] = '{8'h00, 8'h00, 8'h81, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      run_scan(p[i], st, pr);
      checks += 2;
      if (st !== es[i]) begin errors++; $display("FAIL rpt_press_state[%0d]: got %h want %h", i, st, es[i]); end
      if (pr !== ep[i]) begin errors++; $display("FAIL rpt_press_pulse[%0d]: got %h want %h", i, pr, ep[i]); end
    end
    for (int h = 1; h <= 12; h++) begin
      exp_pr = (h == 5 || h == 7 || h == 9 || h == 11) ? 8'h01 : 8'h00;
      run_scan(8'h81, st, pr);
      checks += 2;
      if (st !== 8'h81)  begin errors++; $display("FAIL rpt_hold_state[%0d]: got %h want 81", h, st); end
      if (pr !== exp_pr) begin errors++; $display("FAIL rpt_hold_pulse[%0d]: got %h want %h", h, pr, exp_pr); end
    end
    for (int i = 3; i < 6; i++) begin
      run_scan(p[i], st, pr);
      checks += 2;
      if (st !== es[i]) begin errors++; $display("FAIL rpt_rel_state[%0d]: got %h want %h", i, st, es[i]); end
      if (pr !== ep[i]) begin errors++; $display("FAIL rpt_rel_pulse[%0d]: got %h want %h", i, pr, ep[i]); end
    end
  endtask

  task automatic test_enable();
    logic [NB-1:0] st, pr;
    bit ok;
    int lows = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 3; i++) run_scan(8'h10, st, pr);
    checks++;
    if (st !== 8'h10) begin errors++; $display("FAIL en_setup_state: got %h want 10", st); end
    par = 8'h00;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.sh_ld_n_o === 1'b0) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL en_load_timeout: got none want load"); end
    repeat (6) @(negedge clk);
    enable = 1'b0;
    wait_done(ok);
    checks++;
    if (ok && btn_state !== 8'h10) begin errors++; $display("FAIL en_inflight_state: got %h want 10", btn_state); end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.sh_ld_n_o === 1'b0) lows++;
    end
    checks += 2;
    if (lows !== 0)          begin errors++; $display("FAIL en_no_load: got %0d want 0", lows); end
    if (btn_state !== 8'h10) begin errors++; $display("FAIL en_hold_state: got %h want 10", btn_state); end
    enable = 1'b1;
    run_scan(8'h00, st, pr);
    checks++;
    if (st !== 8'h10) begin errors++; $display("FAIL en_resume1: got %h want 10", st); end
    run_scan(8'h00, st, pr);
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL en_resume2: got %h want 00", st); end
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] st, pr;
    bit seen = 1'b0;
    int first_low = -1;
    for (int i = 0; i < 3; i++) run_scan(8'h10, st, pr);
    checks++;
    if (st !== 8'h10) begin errors++; $display("FAIL rm_setup_state: got %h want 10", st); end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.sclk_o === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rm_sclk_timeout: got none want sclk high"); end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.sclk_o !== 1'b0)    begin errors++; $display("FAIL rm_sclk: got %b want 0", bus.sclk_o); end
    if (bus.sh_ld_n_o !== 1'b1) begin errors++; $display("FAIL rm_sh_ld_n: got %b want 1", bus.sh_ld_n_o); end
    if (btn_state !== 8'h00)    begin errors++; $display("FAIL rm_state: got %h want 00", btn_state); end
    if (scan_done !== 1'b0)     begin errors++; $display("FAIL rm_done: got %b want 0", scan_done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 200; e++) begin
      @(negedge clk);
      if (bus.sh_ld_n_o === 1'b0) begin first_low = e; break; end
    end
    checks++;
    if (first_low !== 64) begin errors++; $display("FAIL rm_restart: got %0d want 64", first_low); end
  endtask

  initial begin
    test_reset();
    test_waveform();
    test_bit_order();
    test_bounce();
    test_repeat();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
